exe_mem_pipe_reg: RTL
=====================

# exe_mem_pipe_reg

Parametrised EXE→MEM pipeline stage register with a valid/ready handshake, stall enable, synchronous flush and an optional two-entry skid buffer. It carries the control word, source register value, source register address, ALU result and target register value from the execute stage to the memory stage. It replaces the fixed-width, always-load stage register with one that can absorb back-pressure and insert bubbles.

## Interface
Parameters:
- CTRL_W, 17, control word width
- DATA_W, 32, width of srcReg, alu and Robj fields
- DIR_W, 4, register address width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- EN  in  1  stage enable; 0 = freeze all state
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  EXE presents a beat
- in_ready  out  1  stage accepts a beat this cycle
- i_ctrl  in  CTRL_W  control word
- i_srcReg  in  DATA_W  source register value
- i_srcRegDir  in  DIR_W  source register address
- i_alu  in  DATA_W  ALU result
- i_Robj  in  DATA_W  target register value
- out_valid  out  1  beat available to MEM
- out_ready  in  1  MEM consumes the beat
- o_ctrl, o_srcReg, o_srcRegDir, o_alu, o_Robj  out  matching widths  output beat fields

## Operation
- Accept = in_valid & in_ready. Drain = out_valid & out_ready & EN.
- Main register M drives all o_* fields; out_valid = M.valid.
- o_ctrl reads all-zero whenever out_valid = 0 (bubble = NOP for MEM); other o_* fields hold their last loaded value.
- With skid (see Configuration): second register S; in_ready = EN & !S.valid, purely from flops.
  - Drain & S.valid: M ← S, S cleared; a simultaneous Accept loads S.
  - Drain & !S.valid: M ← input if Accept, else M.valid ← 0.
  - No drain & M.valid & Accept: S ← input.
  - No drain & !M.valid & Accept: M ← input.
- EN = 0: no state changes, in_ready = 0, outputs hold; out_ready is ignored (no drain).
- flush = 1: M.valid and S.valid cleared next edge regardless of EN or handshakes; the input beat in that cycle is dropped even if in_ready was 1; a beat presented on out_* in that cycle counts as consumed only if out_ready = 1.
- Priority: rst_n low > flush > EN > handshake.
- Reset: M and S valid = 0, all data fields = 0; thus out_valid = 0, o_* = 0, in_ready = 1 from the first cycle after reset with EN = 1.
- Beat order is strictly preserved; no beat is duplicated or lost except by flush.

## Timing
- Latency: beat accepted at edge N appears on o_* with out_valid = 1 after edge N.
- Throughput: one beat per cycle sustained when out_ready = 1.
- With skid, in_ready deasserts one cycle after the first un-drained accept while M is full; two beats are absorbed after MEM stalls.
- Without skid, in_ready is combinational from out_ready and EN.
- Back-to-back flush and accept: accept on the cycle after flush is legal and loads M.

## Configuration
- EXE_MEM_SKID_EN defined: two-entry M+S buffer, registered in_ready as above.
- Undefined: single register M only; in_ready = EN & (!M.valid | out_ready); on Drain & Accept, M ← input in the same edge; S and its logic absent. All other behaviour (flush, EN, reset, bubble o_ctrl) identical.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1, i_alu = 0x1234 -> out_valid = 0, o_* = 0, in_ready = 1 after release.
- Streaming: 8 beats i_alu = 1..8, out_ready = 1 -> o_alu 1..8 one cycle later each, no gaps.
- Back-pressure (skid build): out_ready = 0 while sending alu = 0xA, 0xB, 0xC -> in_ready falls after second beat; releasing out_ready yields 0xA then 0xB then 0xC, nothing lost.
- Flush: M and S full, flush = 1 with in_valid = 1 (alu = 0xD) -> next cycle out_valid = 0, o_ctrl = 0, 0xD never appears.
- Stall: EN = 0 for 3 cycles with out_ready = 1 and a held beat alu = 0x55 -> out_valid stays 1, o_alu = 0x55, in_ready = 0; drains on EN = 1.
- Non-skid build: repeat streaming and back-pressure -> in_ready follows out_ready same cycle, order preserved.

Source files
------------

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM stage register with valid/ready handshake, stall enable and flush.
// Define EXE_MEM_SKID_EN to build the two-entry (main + skid) variant with registered in_ready.
module exe_mem_pipe_reg #(
  parameter int unsigned CTRL_W = 17,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_srcReg,
  input  logic [DIR_W-1:0]  i_srcRegDir,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_Robj,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_srcReg,
  output logic [DIR_W-1:0]  o_srcRegDir,
  output logic [DATA_W-1:0] o_alu,
  output logic [DATA_W-1:0] o_Robj
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] src_reg;
    logic [DIR_W-1:0]  src_dir;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] robj;
  } beat_t;

  beat_t in_beat;
  beat_t m_q;
  logic  m_valid;
  logic  accept;
  logic  drain;

  always_comb begin
    in_beat.ctrl    = i_ctrl;
    in_beat.src_reg = i_srcReg;
    in_beat.src_dir = i_srcRegDir;
    in_beat.alu     = i_alu;
    in_beat.robj    = i_Robj;
  end

  assign accept = in_valid & in_ready;
  assign drain  = m_valid & out_ready & EN;

`ifdef EXE_MEM_SKID_EN
  beat_t s_q;
  logic  s_valid;

  // in_ready depends only on EN and the skid flop, breaking the out_ready path
  assign in_ready = EN & ~s_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (EN) begin
      if (drain && s_valid) begin
        m_q     <= s_q;
        s_valid <= accept;
        if (accept) s_q <= in_beat;
      end else if (drain) begin
        m_valid <= accept;
        if (accept) m_q <= in_beat;
      end else if (accept) begin
        if (m_valid) begin
          s_q     <= in_beat;
          s_valid <= 1'b1;
        end else begin
          m_q     <= in_beat;
          m_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign in_ready = EN & (~m_valid | out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (EN) begin
      if (accept) begin
        m_q     <= in_beat;
        m_valid <= 1'b1;
      end else if (drain) begin
        m_valid <= 1'b0;
      end
    end
  end
`endif

  // Bubbles present a zero control word so MEM sees a NOP
  assign out_valid   = m_valid;
  assign o_ctrl      = m_valid ? m_q.ctrl : '0;
  assign o_srcReg    = m_q.src_reg;
  assign o_srcRegDir = m_q.src_dir;
  assign o_alu       = m_q.alu;
  assign o_Robj      = m_q.robj;

endmodule
